// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS-32 datapath: sequences fetch/decode/execute/
// memory/writeback and drives every datapath enable and mux select.
module mips_multicycle_ctrl #(
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,  S_ADDIWB = 4'd9,  S_BEQ    = 4'd10, S_BNE    = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state, next_state;
    logic   rdy;
    logic   dec_illegal;
    logic   pc_write;

    assign rdy       = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign dbg_state = state;

    always_comb begin
        dec_illegal = 1'b1;
        case (opcode)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: dec_illegal = 1'b0;
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            illegal_op <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_DECODE && dec_illegal)
                illegal_op <= 1'b1;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_BNE:       next_state = S_BNE;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next_state = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next_state = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state = S_ALUWB;
            S_ADDIEX: next_state = S_ADDIWB;
            default:  next_state = S_FETCH;
        endcase
    end

    // Moore decode; only the handshake-gated enables and pc_en look at live inputs.
    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = rdy;
                pc_write  = rdy;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                instr_done = dec_illegal;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = rdy;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ, S_BNE: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        pc_en = pc_write | ((state == S_BEQ) & zero) | ((state == S_BNE) & ~zero);
        // Reset suppresses every state-changing strobe so an aborted instruction writes nothing.
        if (!rst_n) begin
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed plan steps plus a random instruction stream,
// each cycle compared against a per-instruction cycle model.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                           OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                           OP_SW = 6'b101011;

    logic       clk = 1'b0;
    logic       rst_n, rst_n2;
    logic [5:0] opcode;
    logic       zero, mem_ready;
    logic       mem_ready2;

    logic       pc_en1, iord1, mr1, mw1, irw1, rd1, m2r1, rw1, asa1, done1, ill1;
    logic [1:0] asb1, aop1, ps1;
    logic [3:0] dbg1;
    logic       pc_en2, iord2, mr2, mw2, irw2, rd2, m2r2, rw2, asa2, done2, ill2;
    logic [1:0] asb2, aop2, ps2;
    logic [3:0] dbg2;

    logic [15:0] o1, o2;
    logic        exp_ill1, exp_ill2;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_HANDSHAKE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en1), .iord(iord1), .mem_read(mr1), .mem_write(mw1), .ir_write(irw1),
        .reg_dst(rd1), .mem_to_reg(m2r1), .reg_write(rw1), .alu_src_a(asa1),
        .alu_src_b(asb1), .alu_op(aop1), .pc_src(ps1), .instr_done(done1),
        .illegal_op(ill1), .dbg_state(dbg1)
    );

    mips_multicycle_ctrl #(.MEM_HANDSHAKE(0)) dut2 (
        .clk(clk), .rst_n(rst_n2), .opcode(opcode), .zero(zero), .mem_ready(mem_ready2),
        .pc_en(pc_en2), .iord(iord2), .mem_read(mr2), .mem_write(mw2), .ir_write(irw2),
        .reg_dst(rd2), .mem_to_reg(m2r2), .reg_write(rw2), .alu_src_a(asa2),
        .alu_src_b(asb2), .alu_op(aop2), .pc_src(ps2), .instr_done(done2),
        .illegal_op(ill2), .dbg_state(dbg2)
    );

    assign o1 = {pc_en1, iord1, mr1, mw1, irw1, rd1, m2r1, rw1, asa1, asb1, aop1, ps1, done1};
    assign o2 = {pc_en2, iord2, mr2, mw2, irw2, rd2, m2r2, rw2, asa2, asb2, aop2, ps2, done2};

    function automatic logic [15:0] mk(input logic pe, io, mr, mw, irw, rd, m2r, rw, asa,
                                       input logic [1:0] asb, aop, ps, input logic dn);
        return {pe, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ps, dn};
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op == OP_R || op == OP_J || op == OP_BEQ || op == OP_BNE ||
               op == OP_ADDI || op == OP_LW || op == OP_SW;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive inputs for one cycle, compare outputs mid-cycle, then advance past the edge.
    task automatic step(input int sel, input logic [5:0] op, input logic z, input logic rdy,
                        input logic [15:0] exp, input string tag);
        logic [15:0] got;
        logic        got_ill, want_ill;
        opcode = op; zero = z; mem_ready = rdy;
        #1;
        got      = (sel != 0) ? o2 : o1;
        got_ill  = (sel != 0) ? ill2 : ill1;
        want_ill = (sel != 0) ? exp_ill2 : exp_ill1;
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: outputs got=%h expected=%h", tag, got, exp);
        end
        checks++;
        assert (got_ill === want_ill) else begin
            failures++;
            $error("FAIL %s_illegal: got=%b expected=%b", tag, got_ill, want_ill);
        end
        @(posedge clk);
        #1;
    endtask

    // Reference: the cycle-by-cycle control pattern each instruction class must produce.
    task automatic run_instr(input int sel, input logic [5:0] op, input int wf, input int wm,
                             input logic z);
        logic [5:0] any_op;
        for (int i = 0; i < wf; i++) begin
            any_op = 6'($urandom_range(0, 63));
            step(sel, any_op, rbit(), 1'b0, mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), "fetch_wait");
        end
        any_op = 6'($urandom_range(0, 63));
        step(sel, any_op, rbit(), 1'b1, mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), "fetch");
        step(sel, op, rbit(), rbit(),
             mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,!is_legal(op)), "decode");
        if (!is_legal(op)) begin
            if (sel != 0) exp_ill2 = 1'b1; else exp_ill1 = 1'b1;
        end
        case (op)
            OP_LW: begin
                step(sel, op, rbit(), rbit(), mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "lw_adr");
                for (int i = 0; i < wm; i++)
                    step(sel, op, rbit(), 1'b0, mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "lw_rd_wait");
                step(sel, op, rbit(), 1'b1, mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "lw_rd");
                step(sel, op, rbit(), rbit(), mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1), "lw_wb");
            end
            OP_SW: begin
                step(sel, op, rbit(), rbit(), mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "sw_adr");
                for (int i = 0; i < wm; i++)
                    step(sel, op, rbit(), 1'b0, mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), "sw_wr_wait");
                step(sel, op, rbit(), 1'b1, mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1), "sw_wr");
            end
            OP_R: begin
                step(sel, op, rbit(), rbit(), mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), "r_exec");
                step(sel, op, rbit(), rbit(), mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1), "r_wb");
            end
            OP_ADDI: begin
                step(sel, op, rbit(), rbit(), mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "addi_ex");
                step(sel, op, rbit(), rbit(), mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1), "addi_wb");
            end
            OP_BEQ: step(sel, op, z, rbit(), mk(z,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1), "beq");
            OP_BNE: step(sel, op, z, rbit(), mk(!z,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1), "bne");
            OP_J:   step(sel, op, rbit(), rbit(), mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1), "jump");
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
        rst_n = 1'b0; rst_n2 = 1'b0; mem_ready2 = 1'b0;
        opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        exp_ill1 = 1'b0; exp_ill2 = 1'b0;

        // Reset: after one edge in reset the machine sits in FETCH with strobes suppressed.
        @(posedge clk); #1;
        step(0, 6'h3f, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), "reset_fetch");
        rst_n = 1'b1;

        // Plan 1: lw with memory always ready.
        run_instr(0, OP_LW, 0, 0, 1'b0);
        // Plan 2: beq taken / not taken, bne taken.
        run_instr(0, OP_BEQ, 0, 0, 1'b1);
        run_instr(0, OP_BEQ, 0, 0, 1'b0);
        run_instr(0, OP_BNE, 0, 0, 1'b0);
        // Plan 3: sw with 3 fetch waits and 2 write waits (9 cycles).
        run_instr(0, OP_SW, 3, 2, 1'b0);
        // Plan 4: illegal opcode, then a normal R-type; the flag stays set.
        run_instr(0, 6'b111111, 0, 0, 1'b0);
        run_instr(0, OP_R, 0, 0, 1'b0);

        // Plan 5: reset while lw waits in MEMRD aborts it with no writeback.
        run_instr(0, OP_R, 1, 0, 1'b0);
        step(0, 6'h00, 1'b0, 1'b1, mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), "p5_fetch");
        step(0, OP_LW, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), "p5_decode");
        step(0, OP_LW, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "p5_adr");
        rst_n = 1'b0;
        step(0, OP_LW, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "p5_rd_in_reset");
        exp_ill1 = 1'b0;
        rst_n = 1'b1;
        run_instr(0, OP_J, 0, 0, 1'b0);

        // Random instruction stream with random handshake stalls.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            end else begin
                op = ops[$urandom_range(0, 6)];
            end
            run_instr(0, op, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
        end

        // Plan 6: no-handshake instance with mem_ready tied low: addi then R-type, 4 + 4 cycles.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n2 = 1'b1;
        run_instr(1, OP_ADDI, 0, 0, 1'b0);
        run_instr(1, OP_R, 0, 0, 1'b0);
        run_instr(1, OP_LW, 0, 0, 1'b0);
        run_instr(1, OP_SW, 0, 0, 1'b0);
        run_instr(1, OP_BNE, 0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS-32 datapath, replacing the single-cycle combinational decoder. It sequences each instruction through fetch, decode, execute, memory and writeback cycles and generates all datapath enables and mux selects. It forms the PC enable internally from the branch condition and the ALU zero flag. It also handles a ready handshake with a unified instruction/data memory.

Parameters:
MEM_HANDSHAKE, 1, 1 = fetch and memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active low
opcode  input  6  instr[31:26] from the instruction register
zero  input  1  ALU zero flag (combinational, current cycle)
mem_ready  input  1  memory completes the current access this cycle
pc_en  output  1  PC register write enable
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
reg_dst  output  1  register destination select: 0 = rt, 1 = rd
mem_to_reg  output  1  writeback data select: 0 = ALUOut, 1 = MDR
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A
alu_src_b  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
alu_op  output  2  00 = add, 01 = sub, 10 = funct decode
pc_src  output  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  output  1  one-cycle pulse in the final cycle of each instruction
illegal_op  output  1  sticky flag, set on an unsupported opcode

Behaviour:
- The state register is 4 bits and changes on the rising clk edge.
- Outputs are Moore-decoded from the state, except pc_en and the mem_ready-gated enables listed below.
- States:
  - FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write=mem_ready and pc_write=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BEQ
    - 000101 (bne) -> BNE
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH, set illegal_op, pulse instr_done
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: iord=1, mem_read=1. Waits for mem_ready, then -> MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. -> FETCH.
  - MEMWR: iord=1, mem_write=1, held until mem_ready. instr_done=mem_ready. -> FETCH when mem_ready=1.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. -> ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. -> FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. -> FETCH.
  - BEQ and BNE: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, instr_done=1. -> FETCH.
  - JUMP: pc_src=10, pc_write=1, instr_done=1. -> FETCH.
- pc_en = pc_write | (state==BEQ & zero) | (state==BNE & ~zero). This is combinational and must not be registered.
- Every signal not listed for a state is 0 in that state.
- Reset: while rst_n=0, pc_en, ir_write, mem_read, mem_write, reg_write and instr_done are forced to 0 combinationally. At the first clk edge with rst_n=0, state <= FETCH and illegal_op <= 0.
- Reset mid-instruction (any state, including a mem_ready wait) aborts the instruction; no partial writeback occurs.
- illegal_op is cleared only by reset.
- MEM_HANDSHAKE=0: every instruction takes a fixed number of cycles:
  - lw = 5
  - sw = 4
  - R-type = 4
  - addi = 4
  - beq/bne = 3
  - j = 3
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Unreachable state encodings -> FETCH on the next edge, with all outputs 0 meanwhile.
- Control outputs change only on state transitions; they do not glitch on opcode changes outside DECODE.

Test Plan:
1. Reset, then lw (opcode 100011) with mem_ready tied to 1 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 only in cycle 5; instr_done pulses once in cycle 5.
2. beq with zero=1, then beq with zero=0 -> pc_en=1 in the BEQ cycle for the first and 0 for the second. bne with zero=0 -> pc_en=1 in the BNE cycle, with pc_src=01.
3. sw with mem_ready held low for 3 cycles in FETCH and 2 cycles in MEMWR -> ir_write pulses once; mem_write stays high for 3 cycles; total 9 cycles; instr_done coincides with mem_ready in MEMWR.
4. Opcode 111111 -> returns to FETCH after DECODE; illegal_op=1 and stays set; reg_write, mem_write and pc_en remain 0. The following R-type instruction executes normally in 4 cycles.
5. Reset asserted in MEMRD while mem_ready=0 -> no reg_write; state is FETCH after the edge; a subsequent j asserts pc_en with pc_src=10 in cycle 3.
6. With MEM_HANDSHAKE=0 and mem_ready tied to 0, run addi followed by an R-type -> 4 + 4 cycles; ALUWB shows reg_dst=1; ADDIWB shows reg_dst=0.
